// File: rtl/adc_conv_sequencer.sv
// Conversion sequencer for the SAR ADC control core: gates the ADC reset, spaces
// conversions, and buffers results in a FIFO. Define ADC_SEQ_WATCHDOG_EN for the stall watchdog.
module adc_conv_sequencer #(
    parameter int RESULT_BITS = 16,
    parameter int FIFO_DEPTH  = 4,
    parameter int BURST_BITS  = 8,
    parameter int GAP_BITS    = 16,
    parameter int TIMEOUT     = 4096
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cfg_start,
    input  logic                   cfg_stop,
    input  logic                   cfg_continuous,
    input  logic [BURST_BITS-1:0]  cfg_burst_len,
    input  logic [GAP_BITS-1:0]    cfg_gap,
    output logic                   adc_rst_n,
    input  logic                   adc_conv_done,
    input  logic [RESULT_BITS-1:0] adc_result,
    output logic [RESULT_BITS-1:0] res_data,
    output logic                   res_last,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic                   busy,
    output logic                   overflow,
    output logic                   timeout_err,
    input  logic                   clear_err
);
    localparam int AW = $clog2(FIFO_DEPTH);

    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || TIMEOUT < 2) begin : g_param_check
        $error("adc_conv_sequencer: bad FIFO_DEPTH or TIMEOUT");
    end

    typedef enum logic [1:0] {IDLE, RUN, GAP} state_t;

    state_t                state;
    logic [BURST_BITS-1:0] len_q;
    logic [BURST_BITS-1:0] remaining;
    logic [GAP_BITS-1:0]   gap_q;
    logic [GAP_BITS-1:0]   gap_cnt;
    logic                  cont_q;

    logic [RESULT_BITS:0]  mem [FIFO_DEPTH];
    logic [AW:0]           wr_ptr;
    logic [AW:0]           rd_ptr;
    logic                  full;
    logic                  push;
    logic                  pop;
    logic                  last;
    logic                  wd_fire;

    assign last      = (remaining == BURST_BITS'(1));
    assign push      = (state == RUN) && adc_conv_done && !cfg_stop;
    assign res_valid = (wr_ptr != rd_ptr);
    assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop       = res_valid && res_ready;
    assign res_data  = res_valid ? mem[rd_ptr[AW-1:0]][RESULT_BITS-1:0] : '0;
    assign res_last  = res_valid ? mem[rd_ptr[AW-1:0]][RESULT_BITS] : 1'b0;

`ifdef ADC_SEQ_WATCHDOG_EN
    localparam int WDW = $clog2(TIMEOUT) + 1;
    logic [WDW-1:0] wd_cnt;

    // A done in the same cycle counts as progress, so it suppresses the fire.
    assign wd_fire = (state == RUN) && !cfg_stop && !adc_conv_done
                     && (wd_cnt == WDW'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (!rst)
            wd_cnt <= '0;
        else if (state == RUN && !adc_conv_done)
            wd_cnt <= wd_cnt + 1'b1;
        else
            wd_cnt <= '0;
    end

    always_ff @(posedge clk) begin
        if (!rst)
            timeout_err <= 1'b0;
        else if (wd_fire)
            timeout_err <= 1'b1;
        else if (clear_err)
            timeout_err <= 1'b0;
    end
`else
    assign wd_fire     = 1'b0;
    assign timeout_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            adc_rst_n <= 1'b0;
            busy      <= 1'b0;
            len_q     <= '0;
            remaining <= '0;
            gap_q     <= '0;
            gap_cnt   <= '0;
            cont_q    <= 1'b0;
        end else if (cfg_stop || wd_fire) begin
            state     <= IDLE;
            adc_rst_n <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (cfg_start) begin
                        len_q     <= (cfg_burst_len == '0) ? BURST_BITS'(1) : cfg_burst_len;
                        remaining <= (cfg_burst_len == '0) ? BURST_BITS'(1) : cfg_burst_len;
                        gap_q     <= cfg_gap;
                        cont_q    <= cfg_continuous;
                        state     <= RUN;
                        adc_rst_n <= 1'b1;
                        busy      <= 1'b1;
                    end
                end
                RUN: begin
                    if (adc_conv_done) begin
                        remaining <= (last && cont_q) ? len_q : remaining - 1'b1;
                        if (last && !cont_q) begin
                            state     <= IDLE;
                            adc_rst_n <= 1'b0;
                            busy      <= 1'b0;
                        end else if (gap_q != '0) begin
                            state     <= GAP;
                            adc_rst_n <= 1'b0;
                            gap_cnt   <= gap_q;
                        end
                    end
                end
                GAP: begin
                    if (gap_cnt == GAP_BITS'(1)) begin
                        state     <= RUN;
                        adc_rst_n <= 1'b1;
                    end else begin
                        gap_cnt <= gap_cnt - 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    adc_rst_n <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

    // A push into a full FIFO still lands when the head is popped in the same cycle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && (!full || pop)) begin
                mem[wr_ptr[AW-1:0]] <= {last, adc_result};
                wr_ptr              <= wr_ptr + 1'b1;
            end
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst)
            overflow <= 1'b0;
        else if (push && full && !pop)
            overflow <= 1'b1;
        else if (clear_err)
            overflow <= 1'b0;
    end

endmodule

// File: tb/tb_adc_conv_sequencer.sv
// Directed self-checking bench for adc_conv_sequencer (watchdog scenario under ADC_SEQ_WATCHDOG_EN).
module tb_adc_conv_sequencer;
    logic        clk = 1'b0;
    logic        rst;
    logic        cfg_start, cfg_stop, cfg_continuous;
    logic [7:0]  cfg_burst_len;
    logic [15:0] cfg_gap;
    logic        adc_rst_n;
    logic        adc_conv_done;
    logic [15:0] adc_result;
    logic [15:0] res_data;
    logic        res_last, res_valid, res_ready;
    logic        busy, overflow, timeout_err, clear_err;

    int checks = 0;
    int errors = 0;

    adc_conv_sequencer #(
        .RESULT_BITS(16),
        .FIFO_DEPTH (4),
        .BURST_BITS (8),
        .GAP_BITS   (16),
        .TIMEOUT    (16)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .cfg_start     (cfg_start),
        .cfg_stop      (cfg_stop),
        .cfg_continuous(cfg_continuous),
        .cfg_burst_len (cfg_burst_len),
        .cfg_gap       (cfg_gap),
        .adc_rst_n     (adc_rst_n),
        .adc_conv_done (adc_conv_done),
        .adc_result    (adc_result),
        .res_data      (res_data),
        .res_last      (res_last),
        .res_valid     (res_valid),
        .res_ready     (res_ready),
        .busy          (busy),
        .overflow      (overflow),
        .timeout_err   (timeout_err),
        .clear_err     (clear_err)
    );

    always #5 clk = ~clk;

    // Inputs change and outputs are sampled on the falling edge.
    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic start_burst(input logic [7:0] len, input logic [15:0] gap, input logic cont);
        cfg_burst_len  = len;
        cfg_gap        = gap;
        cfg_continuous = cont;
        cfg_start      = 1'b1;
        cyc();
        cfg_start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        cyc();
        cyc();
        checks++; if (adc_rst_n !== 1'b0) begin errors++; $display("FAIL reset_adc_rst_n got %0b want 0", adc_rst_n); end
        checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL reset_res_valid got %0b want 0", res_valid); end
        checks++; if (res_data !== 16'h0) begin errors++; $display("FAIL reset_res_data got %h want 0000", res_data); end
        checks++; if (res_last !== 1'b0) begin errors++; $display("FAIL reset_res_last got %0b want 0", res_last); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b want 0", busy); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got %0b want 0", overflow); end
        checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL reset_timeout_err got %0b want 0", timeout_err); end
        rst = 1'b1;
        cyc();
    endtask

    task automatic test_single_burst();
        logic [15:0] vals [3];
        vals[0] = 16'h0101; vals[1] = 16'h0202; vals[2] = 16'h0303;
        res_ready = 1'b1;
        start_burst(8'd3, 16'd2, 1'b0);
        checks++; if (busy !== 1'b1 || adc_rst_n !== 1'b1) begin errors++; $display("FAIL sb_start busy/adc_rst_n got %0b/%0b want 1/1", busy, adc_rst_n); end
        for (int i = 0; i < 3; i++) begin
            adc_conv_done = 1'b1;
            adc_result    = vals[i];
            cyc();
            adc_conv_done = 1'b0;
            checks++; if (res_valid !== 1'b1 || res_data !== vals[i]) begin errors++; $display("FAIL sb_data%0d got v=%0b d=%h want v=1 d=%h", i, res_valid, res_data, vals[i]); end
            checks++; if (res_last !== (i == 2)) begin errors++; $display("FAIL sb_last%0d got %0b want %0b", i, res_last, (i == 2)); end
            if (i < 2) begin
                checks++; if (adc_rst_n !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL sb_gap1_%0d adc_rst_n/busy got %0b/%0b want 0/1", i, adc_rst_n, busy); end
                cyc();
                checks++; if (adc_rst_n !== 1'b0) begin errors++; $display("FAIL sb_gap2_%0d adc_rst_n got %0b want 0", i, adc_rst_n); end
                cyc();
                checks++; if (adc_rst_n !== 1'b1) begin errors++; $display("FAIL sb_gap_end%0d adc_rst_n got %0b want 1", i, adc_rst_n); end
            end else begin
                checks++; if (busy !== 1'b0 || adc_rst_n !== 1'b0) begin errors++; $display("FAIL sb_done busy/adc_rst_n got %0b/%0b want 0/0", busy, adc_rst_n); end
            end
        end
        cyc();
        checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL sb_drained res_valid got %0b want 0", res_valid); end
    endtask

    task automatic test_backpressure();
        res_ready = 1'b0;
        start_burst(8'd6, 16'd0, 1'b0);
        for (int i = 0; i < 6; i++) begin
            adc_conv_done = 1'b1;
            adc_result    = 16'h1000 + 16'(i);
            cyc();
            if (i == 3) begin
                checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL bp_no_ovf_at4 got %0b want 0", overflow); end
            end
            if (i == 4) begin
                checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL bp_ovf_at5 got %0b want 1", overflow); end
            end
        end
        adc_conv_done = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL bp_busy_end got %0b want 0", busy); end
        checks++; if (res_data !== 16'h1000 || res_valid !== 1'b1) begin errors++; $display("FAIL bp_head_hold got v=%0b d=%h want v=1 d=1000", res_valid, res_data); end
        res_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            checks++; if (res_valid !== 1'b1 || res_data !== 16'h1000 + 16'(k) || res_last !== 1'b0) begin
                errors++; $display("FAIL bp_pop%0d got v=%0b d=%h l=%0b want v=1 d=%h l=0", k, res_valid, res_data, res_last, 16'h1000 + 16'(k));
            end
            cyc();
        end
        checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL bp_empty got %0b want 0", res_valid); end
        clear_err = 1'b1;
        cyc();
        clear_err = 1'b0;
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL bp_clear_ovf got %0b want 0", overflow); end
    endtask

    task automatic test_stop_mid_burst();
        res_ready = 1'b0;
        start_burst(8'd8, 16'd0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            adc_conv_done = 1'b1;
            adc_result    = 16'h3000 + 16'(i);
            cfg_stop      = (i == 2);
            cyc();
        end
        adc_conv_done = 1'b0;
        cfg_stop      = 1'b0;
        checks++; if (busy !== 1'b0 || adc_rst_n !== 1'b0) begin errors++; $display("FAIL stop_idle busy/adc_rst_n got %0b/%0b want 0/0", busy, adc_rst_n); end
        res_ready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            checks++; if (res_valid !== 1'b1 || res_data !== 16'h3000 + 16'(k)) begin errors++; $display("FAIL stop_pop%0d got v=%0b d=%h want v=1 d=%h", k, res_valid, res_data, 16'h3000 + 16'(k)); end
            cyc();
        end
        checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL stop_only2 res_valid got %0b want 0", res_valid); end
    endtask

    task automatic test_continuous();
        res_ready = 1'b1;
        start_burst(8'd2, 16'd1, 1'b1);
        for (int i = 0; i < 6; i++) begin
            adc_conv_done = 1'b1;
            adc_result    = 16'h2000 + 16'(i);
            cyc();
            adc_conv_done = 1'b0;
            checks++; if (res_valid !== 1'b1 || res_data !== 16'h2000 + 16'(i) || res_last !== (i % 2 == 1)) begin
                errors++; $display("FAIL cont_res%0d got v=%0b d=%h l=%0b want v=1 d=%h l=%0b", i, res_valid, res_data, res_last, 16'h2000 + 16'(i), (i % 2 == 1));
            end
            checks++; if (busy !== 1'b1 || adc_rst_n !== 1'b0) begin errors++; $display("FAIL cont_gap%0d busy/adc_rst_n got %0b/%0b want 1/0", i, busy, adc_rst_n); end
            cyc();
            checks++; if (adc_rst_n !== 1'b1) begin errors++; $display("FAIL cont_run%0d adc_rst_n got %0b want 1", i, adc_rst_n); end
        end
        cfg_stop = 1'b1;
        cyc();
        cfg_stop = 1'b0;
        checks++; if (busy !== 1'b0 || adc_rst_n !== 1'b0) begin errors++; $display("FAIL cont_stop busy/adc_rst_n got %0b/%0b want 0/0", busy, adc_rst_n); end
    endtask

    task automatic test_start_stop_same();
        cfg_stop = 1'b1;
        start_burst(8'd1, 16'd0, 1'b0);
        cfg_stop = 1'b0;
        checks++; if (busy !== 1'b0 || adc_rst_n !== 1'b0) begin errors++; $display("FAIL start_stop busy/adc_rst_n got %0b/%0b want 0/0", busy, adc_rst_n); end
    endtask

    task automatic test_watchdog();
        start_burst(8'd1, 16'd0, 1'b0);
        repeat (15) cyc();
`ifdef ADC_SEQ_WATCHDOG_EN
        checks++; if (busy !== 1'b1 || timeout_err !== 1'b0) begin errors++; $display("FAIL wd_pre busy/timeout_err got %0b/%0b want 1/0", busy, timeout_err); end
        cyc();
        checks++; if (busy !== 1'b0 || timeout_err !== 1'b1 || adc_rst_n !== 1'b0) begin
            errors++; $display("FAIL wd_fire busy/timeout_err/adc_rst_n got %0b/%0b/%0b want 0/1/0", busy, timeout_err, adc_rst_n);
        end
        clear_err = 1'b1;
        cyc();
        clear_err = 1'b0;
        checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL wd_clear got %0b want 0", timeout_err); end
`else
        repeat (5) cyc();
        checks++; if (busy !== 1'b1 || timeout_err !== 1'b0) begin errors++; $display("FAIL wd_off busy/timeout_err got %0b/%0b want 1/0", busy, timeout_err); end
        cfg_stop = 1'b1;
        cyc();
        cfg_stop = 1'b0;
`endif
    endtask

    task automatic test_reset_mid_op();
        res_ready = 1'b0;
        start_burst(8'd4, 16'd3, 1'b0);
        adc_conv_done = 1'b1; adc_result = 16'h4000;
        cyc();
        adc_conv_done = 1'b0;
        repeat (3) cyc();
        checks++; if (adc_rst_n !== 1'b1) begin errors++; $display("FAIL rmo_run adc_rst_n got %0b want 1", adc_rst_n); end
        adc_conv_done = 1'b1; adc_result = 16'h4001;
        cyc();
        adc_conv_done = 1'b0;
        checks++; if (res_valid !== 1'b1 || adc_rst_n !== 1'b0 || busy !== 1'b1) begin
            errors++; $display("FAIL rmo_pre v/adc_rst_n/busy got %0b/%0b/%0b want 1/0/1", res_valid, adc_rst_n, busy);
        end
        rst = 1'b0;
        cyc();
        checks++; if (res_valid !== 1'b0 || res_data !== 16'h0 || res_last !== 1'b0 || busy !== 1'b0 || adc_rst_n !== 1'b0 || overflow !== 1'b0 || timeout_err !== 1'b0) begin
            errors++; $display("FAIL rmo_reset v/d/l/busy/rstn/ovf/to got %0b/%h/%0b/%0b/%0b/%0b/%0b want 0/0000/0/0/0/0/0",
                               res_valid, res_data, res_last, busy, adc_rst_n, overflow, timeout_err);
        end
        rst = 1'b1;
        cyc();
        checks++; if (res_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rmo_after v/busy got %0b/%0b want 0/0", res_valid, busy); end
    endtask

    initial begin
        rst = 1'b0; cfg_start = 1'b0; cfg_stop = 1'b0; cfg_continuous = 1'b0;
        cfg_burst_len = '0; cfg_gap = '0; adc_conv_done = 1'b0; adc_result = '0;
        res_ready = 1'b0; clear_err = 1'b0;
        cyc();
        test_reset();
        test_single_burst();
        test_backpressure();
        test_stop_mid_burst();
        test_continuous();
        test_start_stop_same();
        test_watchdog();
        test_reset_mid_op();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got running want finished");
        $fatal(1, "simulation time limit");
    end
endmodule

// File: doc/adc_conv_sequencer.md
# adc_conv_sequencer

Sequences conversions of the SAR ADC control core: it gates the ADC's active-low reset to start and stop conversion bursts, spaces conversions by a programmable gap, and captures each `conversion_finished_osr`/`result_osr` pair into a small result FIFO. The FIFO is drained by the host with a valid/ready handshake. The block sits between the host register interface and `adc_top`. It owns the ADC reset pin and the result path, and adds an optional watchdog against a stalled conversion.

## Interface
- `RESULT_BITS`, 16, width of `adc_result`/`res_data` (matches OSR result width)
- `FIFO_DEPTH`, 4, result FIFO entries; power of two, ≥2
- `BURST_BITS`, 8, width of burst-length field
- `GAP_BITS`, 16, width of inter-conversion gap field
- `TIMEOUT`, 4096, watchdog limit in cycles (used only with watchdog compiled in)

Ports:
- `clk`  in  1  single clock; all logic on rising edge
- `rst`  in  1  reset; synchronous, active-low
- `cfg_start`  in  1  pulse; starts a burst; ignored unless IDLE
- `cfg_stop`  in  1  pulse; aborts from any state
- `cfg_continuous`  in  1  repeat bursts until stopped
- `cfg_burst_len`  in  BURST_BITS  conversions per burst; 0 treated as 1
- `cfg_gap`  in  GAP_BITS  cycles the ADC is held in reset between conversions
- `adc_rst_n`  out  1  drives the ADC control core reset; low = ADC held idle
- `adc_conv_done`  in  1  ADC `conversion_finished_osr` pulse
- `adc_result`  in  RESULT_BITS  ADC `result_osr`, valid with `adc_conv_done`
- `res_data`  out  RESULT_BITS  FIFO head
- `res_last`  out  1  head entry is the last of its burst
- `res_valid`  out  1  FIFO non-empty
- `res_ready`  in  1  host accepts head when `res_valid`
- `busy`  out  1  state ≠ IDLE
- `overflow`  out  1  sticky; result dropped because FIFO full
- `timeout_err`  out  1  sticky; watchdog fired
- `clear_err`  in  1  pulse; clears `overflow` and `timeout_err`

## Operation
- Reset values:
  - `adc_rst_n`=0, `res_data`=0, `res_last`=0, `res_valid`=0, `busy`=0, `overflow`=0, `timeout_err`=0.
  - FIFO empty, state IDLE, all counters 0.
- States: IDLE, RUN, GAP.
- IDLE:
  - `adc_rst_n`=0.
  - On `cfg_start`: latch `cfg_burst_len` (0→1), `cfg_gap`, and `cfg_continuous`; load remaining count; go to RUN.
- RUN:
  - `adc_rst_n`=1.
  - On `adc_conv_done`: push {`adc_result`, last}, where last = (remaining==1). Then decrement remaining.
  - Next state after a push:
    - If last and not continuous → IDLE.
    - Otherwise, if latched gap==0, stay in RUN. If last, reload remaining.
    - Otherwise → GAP, with the gap counter loaded to the latched gap.
- GAP:
  - `adc_rst_n`=0.
  - Counter decrements each cycle; when it reaches 1, go to RUN.
- `cfg_stop` has priority over everything: next state is IDLE and `adc_rst_n`=0.
  - An `adc_conv_done` in the same cycle is discarded.
  - FIFO contents are retained.
- `cfg_start` and `cfg_stop` in the same cycle: stop wins.
- FIFO behaviour:
  - Pop when `res_valid && res_ready`.
  - Push while full without a same-cycle pop: drop the result and set `overflow`. The burst count still advances.
  - Push and pop in the same cycle while full: push accepted.
- `clear_err` clears both sticky flags. If a flag's set condition occurs in the same cycle, set wins.
- Pointers are log2(FIFO_DEPTH)+1 bits and wrap naturally. Full = MSBs differ and the rest of the bits are equal.

## Timing
- `cfg_start` at cycle N → `busy`=1 and `adc_rst_n`=1 at N+1.
- `adc_conv_done` at cycle M into an empty FIFO → `res_valid`=1 with data at M+1.
- Handshake:
  - `res_data` and `res_last` are stable while `res_valid && !res_ready`.
  - The next head appears the cycle after a pop.
- GAP of G cycles: `adc_rst_n` is low for exactly G cycles.
- Last conversion of a non-continuous burst at M → `busy`=0 at M+1.

## Configuration
- Macro: `ADC_SEQ_WATCHDOG_EN`.
- With the macro defined:
  - A cycle counter runs in RUN. It clears on entry to RUN and on each `adc_conv_done`.
  - When it reaches TIMEOUT−1: set `timeout_err` and go to IDLE. `adc_rst_n` goes low the next cycle; the burst is aborted and the FIFO is retained.
- Without the macro: no counter; `timeout_err` is tied 0.

## Test plan
- Single burst: burst_len=3, gap=2, continuous=0, `res_ready`=1, ADC returns 0x0101, 0x0202, 0x0303.
  - Required: three results in order, `res_last` only on 0x0303.
  - Required: `adc_rst_n` low for exactly 2 cycles between conversions; `busy`=0 one cycle after the third done.
- Backpressure: FIFO_DEPTH=4, burst_len=6, gap=0, `res_ready`=0.
  - Required: 4 entries held, `overflow`=1 after the fifth done.
  - Then `res_ready`=1: exactly 4 pops with the first four values.
- Stop mid-burst: burst_len=8; `cfg_stop` asserted in the same cycle as the third `adc_conv_done`.
  - Required: only 2 results pushed; IDLE and `adc_rst_n`=0 next cycle.
- Continuous: burst_len=2, continuous=1, 6 dones.
  - Required: `res_last` on the 2nd, 4th and 6th results; still `busy`.
  - `cfg_stop` → IDLE.
- Watchdog (macro on, TIMEOUT=16): start, no `adc_conv_done`.
  - Required: `timeout_err`=1 and IDLE 16 cycles after RUN entry.
  - `clear_err` → `timeout_err`=0.
- Reset mid-operation: `rst`=0 during GAP with 2 FIFO entries.
  - Required: after the next edge, all outputs at their reset values and the FIFO empty.
